int_to_floating_point_pipelined: RTL and testbench
==================================================

// Module: int_to_floating_point_pipelined
// PURPOSE
//  Converts a 32-bit two's-complement integer into an IEEE-754 single-precision word. Used as the
//  operand source for the pipelined floating-point add/sub unit, so integer data can enter the FPU.
//  Three-stage pipeline with a valid/ready handshake and backpressure. Rounding is round-to-nearest-even.
// PARAMETERS
//  DATA_WIDTH  32   integer input width and floating output width
//  MENT_WIDTH  23   stored mantissa width
//  EXPO_WIDTH  8    exponent width
//  EXPO_BIAS   127  exponent bias
// PORTS
//  clk_in        input   1           single clock; all state updates on its rising edge
//  reset_in      input   1           asynchronous reset, active-high
//  valid_in      input   1           integer_in holds a valid sample
//  ready_out     output  1           block accepts a sample this cycle
//  integer_in    input   DATA_WIDTH  signed two's-complement operand
//  valid_out     output  1           floating_out holds a valid result
//  ready_in      input   1           downstream accepts the result this cycle
//  floating_out  output  DATA_WIDTH  {sign, exponent, mantissa} result
// BEHAVIOUR
//  Reset (asynchronous, active-high)
//   - While reset_in=1: all stage valid bits, valid_out and floating_out are 0.
//   - ready_out reads 1 (it follows the advance equation below).
//   - Reset asserted mid-operation discards every in-flight sample. No partial result appears afterwards.
//  Pipeline advance
//   - advance = ~valid_out | ready_in.
//   - All three stages shift together when advance=1 and hold when advance=0. ready_out = advance.
//   - A sample is accepted when valid_in & ready_out. Its result gives valid_out=1 exactly 3 advancing
//     cycles later.
//   - Bubbles do not collapse. A stage holding valid=0 still occupies its slot.
//   - While valid_out=1 & ready_in=0, floating_out and valid_out are held stable, and no sample is
//     accepted or lost.
//   - A transfer occurs when valid_out & ready_in. A new result may be accepted in that same cycle
//     (full throughput: 1 result per cycle).
//  Stage 1 (sign / magnitude)
//   - sign = integer_in[31].
//   - mag (32-bit unsigned) = sign ? -integer_in : integer_in.
//   - -2^31 yields mag=0x80000000.
//  Stage 2 (normalise)
//   - lz = leading-zero count of mag (0..31).
//   - norm = mag << lz, so the hidden 1 is at bit 31.
//   - exp = EXPO_BIAS + 31 - lz.
//   - zero_flag = (mag==0).
//  Stage 3 (round / pack)
//   - Bits: kept = norm[30:8], guard = norm[7], sticky = |norm[6:0].
//   - Round up if guard & (sticky | kept[0]).
//   - Mantissa carry-out (kept all ones + 1) zeroes the mantissa and increments exp by 1.
//   - zero_flag forces output 0x00000000. Negative zero is never produced.
//   - Overflow, NaN and denormal outputs are impossible for this input range.
//  No FSM beyond the 3 valid bits. No internal counters.
// TESTING
//  1. integer_in=1, ready_in=1 -> 0x3F800000 with valid_out on the 3rd cycle after acceptance.
//  2. Sign and edge values:
//     -1 -> 0xBF800000; 0 -> 0x00000000; 0x80000000 (-2^31) -> 0xCF000000;
//     0x7FFFFFFF -> 0x4F000000 (rounds up).
//  3. Rounding:
//     16777217 (2^24+1) -> 0x4B800000 (tie, even, down);
//     16777219 -> 0x4B800002 (tie, up);
//     33554431 -> 0x4C000000 (carry increments exponent).
//  4. Backpressure: stream 1,2,3,4 with ready_in=0 for 5 cycles after the first valid_out.
//     -> floating_out stays 0x3F800000, ready_out=0.
//     Then 0x3F800000, 0x40000000, 0x40400000, 0x40800000 in order, none lost or duplicated.
//  5. Bubbles: valid_in pattern 1,0,1 with ready_in=1.
//     -> valid_out pattern 1,0,1 delayed 3 cycles, with matching data.
//  6. Assert reset_in for 1 cycle with 2 samples in flight.
//     -> valid_out=0 immediately, and no result emerges afterwards.
//     A new sample (5) then gives 0x40A00000 after 3 cycles.

Source files
------------

// File: rtl/int_to_floating_point_pipelined.sv
// int_to_floating_point_pipelined
//   Converts a signed two's-complement integer into an IEEE-754 single-precision
//   word. Rounding is round-to-nearest-even. The block is a three-stage pipeline
//   with a valid/ready handshake. All stages move together on "advance".
//   Stage 1 takes the sign and magnitude.
//   Stage 2 normalises the magnitude (leading-zero count) and forms the exponent.
//   Stage 3 rounds and packs the result.
//
// Ports
//   clk_in        : clock; all state changes on its rising edge
//   reset_in      : asynchronous reset, active-high; clears every stage
//   valid_in      : integer_in carries a sample
//   ready_out     : a sample is accepted this cycle (equals advance)
//   integer_in    : signed operand, DATA_WIDTH bits
//   valid_out     : floating_out carries a result
//   ready_in      : downstream takes the result this cycle
//   floating_out  : {sign, exponent, mantissa}
module int_to_floating_point_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int EXPO_BIAS  = 127
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] integer_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] floating_out
);

  localparam int LZ_WIDTH  = $clog2(DATA_WIDTH);
  // Position of the guard bit in the normalised word. Hidden 1 at the MSB,
  // then MENT_WIDTH kept bits, then guard.
  localparam int GUARD_BIT = DATA_WIDTH - 2 - MENT_WIDTH;

  logic advance;

  // Stage 1 : sign / magnitude
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sign_q,  s1_sign_d;
  logic [DATA_WIDTH-1:0] s1_mag_q,   s1_mag_d;

  // Stage 2 : normalised magnitude and exponent
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_sign_q,  s2_sign_d;
  logic [DATA_WIDTH-1:0] s2_norm_q,  s2_norm_d;
  logic [EXPO_WIDTH-1:0] s2_exp_q,   s2_exp_d;

  // Stage 3 : packed result
  logic                  s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH-1:0] s3_data_q,  s3_data_d;

  // Stage 2 and stage 3 working signals
  logic [LZ_WIDTH-1:0]   lz;
  logic [MENT_WIDTH-1:0] kept;
  logic                  guard_bit;
  logic                  sticky_bit;
  logic                  round_up;
  logic [MENT_WIDTH:0]   mant_sum;
  logic [EXPO_WIDTH-1:0] exp_final;
  logic                  is_zero;

  // A stage may move only when the output slot is empty or is drained now.
  // Bubbles travel like real samples, so nothing collapses.
  assign advance   = ~s3_valid_q | ready_in;
  assign ready_out = advance;

  // Stage 1
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (advance) begin
      s1_valid_d = valid_in;
      s1_sign_d  = integer_in[DATA_WIDTH-1];
      // Negating the most negative value wraps back to 2^(N-1). As an unsigned
      // magnitude this is the correct value.
      s1_mag_d   = integer_in[DATA_WIDTH-1] ? -integer_in : integer_in;
    end
  end

  // Stage 2
  always_comb begin
    // The highest set bit wins, because later iterations overwrite earlier ones.
    lz = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s1_mag_q[i]) lz = LZ_WIDTH'(DATA_WIDTH - 1 - i);
    end

    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_norm_d  = s2_norm_q;
    s2_exp_d   = s2_exp_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_norm_d  = s1_mag_q << lz;
      s2_exp_d   = EXPO_WIDTH'(EXPO_BIAS + DATA_WIDTH - 1) - EXPO_WIDTH'(lz);
    end
  end

  // Stage 3
  always_comb begin
    // After normalisation the MSB is 0 only when the magnitude was 0. So the
    // MSB doubles as the zero flag, and no extra register is needed.
    is_zero    = ~s2_norm_q[DATA_WIDTH-1];
    kept       = s2_norm_q[DATA_WIDTH-2 -: MENT_WIDTH];
    guard_bit  = s2_norm_q[GUARD_BIT];
    sticky_bit = |s2_norm_q[GUARD_BIT-1:0];
    round_up   = guard_bit & (sticky_bit | kept[0]);
    mant_sum   = {1'b0, kept} + (MENT_WIDTH + 1)'(round_up);
    // A carry out of the mantissa leaves the low bits all zero. It moves the
    // value up one binade.
    exp_final  = s2_exp_q + EXPO_WIDTH'(mant_sum[MENT_WIDTH]);

    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    if (advance) begin
      s3_valid_d = s2_valid_q;
      s3_data_d  = is_zero ? '0 : {s2_sign_q, exp_final, mant_sum[MENT_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_norm_q  <= '0;
      s2_exp_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_norm_q  <= s2_norm_d;
      s2_exp_q   <= s2_exp_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
    end
  end

  assign valid_out    = s3_valid_q;
  assign floating_out = s3_data_q;

endmodule

// File: tb/tb_int_to_floating_point_pipelined.sv
// Testbench for int_to_floating_point_pipelined. A reference conversion is
// computed with plain integer arithmetic. A scoreboard queue follows accepted
// samples, and one negedge monitor compares every transfer. It also checks
// hold stability during stalls and quiet outputs during reset. Directed
// sequences check latency, backpressure, bubbles and reset flush.
module tb_int_to_floating_point_pipelined;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] integer_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] floating_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } txn_t;
  txn_t exp_q[$];

  logic        stall_seen = 1'b0;
  logic [31:0] held_data  = '0;

  int_to_floating_point_pipelined dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .integer_in  (integer_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .floating_out(floating_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference: exact binary scaling with round-half-to-even on the discarded bits.
  function automatic logic [31:0] model(input logic [31:0] x);
    logic            sgn;
    longint unsigned m, q, rem, half;
    int              msb, sh;
    logic [7:0]      e;
    sgn = x[31];
    m   = sgn ? (64'h1_0000_0000 - {32'b0, x}) : {32'b0, x};
    if (m == 0) return 32'h0;
    msb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    if (msb <= 23) begin
      q = m << (23 - msb);
    end else begin
      sh   = msb - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q   = q >> 1;
        msb = msb + 1;
      end
    end
    e = 8'(127 + msb);
    return {sgn, e, q[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  // Holds one sample on the inputs until it is accepted (bounded).
  task automatic send(input logic [31:0] v);
    logic acc;
    acc        = 1'b0;
    valid_in   = 1'b1;
    integer_in = v;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_in);
      acc = ready_out;
      @(posedge clk_in);
      #1;
      if (acc) break;
    end
    valid_in = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: sample %08h not accepted, required acceptance within 100 cycles", v);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0 && !valid_out) break;
      @(posedge clk_in);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor. It samples on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    txn_t t;
    if (reset_in) begin
      exp_q.delete();
      stall_seen = 1'b0;
      check("reset_valid_out", {31'b0, valid_out}, 32'd0);
    end else begin
      if (stall_seen) begin
        check("stall_hold_valid", {31'b0, valid_out}, 32'd1);
        check("stall_hold_data", floating_out, held_data);
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %08h, required no result", floating_out);
        end else begin
          t = exp_q.pop_front();
          check("stream_result", floating_out, t.dout);
          $display("xfer in=%08h out=%08h expected=%08h", t.din, floating_out, t.dout);
        end
      end
      stall_seen = valid_out && !ready_in;
      held_data  = floating_out;
      if (valid_in && ready_out) exp_q.push_back('{integer_in, model(integer_in)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] vec_in  [11];
  logic [31:0] vec_out [11];

  initial begin
    vec_in[0]  = 32'd1;        vec_out[0]  = 32'h3F800000;
    vec_in[1]  = 32'hFFFFFFFF; vec_out[1]  = 32'hBF800000;
    vec_in[2]  = 32'd0;        vec_out[2]  = 32'h00000000;
    vec_in[3]  = 32'h80000000; vec_out[3]  = 32'hCF000000;
    vec_in[4]  = 32'h7FFFFFFF; vec_out[4]  = 32'h4F000000;
    vec_in[5]  = 32'd16777217; vec_out[5]  = 32'h4B800000;
    vec_in[6]  = 32'd16777219; vec_out[6]  = 32'h4B800002;
    vec_in[7]  = 32'd33554431; vec_out[7]  = 32'h4C000000;
    vec_in[8]  = -32'd16777219; vec_out[8] = 32'hCB800002;
    vec_in[9]  = 32'd16777215; vec_out[9]  = 32'h4B7FFFFF;
    vec_in[10] = 32'd5;        vec_out[10] = 32'h40A00000;

    reset_in   = 1'b1;
    valid_in   = 1'b0;
    integer_in = '0;
    ready_in   = 1'b1;

    // Reset state
    @(posedge clk_in);
    #1;
    check("reset_valid", {31'b0, valid_out}, 32'd0);
    check("reset_data", floating_out, 32'h0);
    check("reset_ready", {31'b0, ready_out}, 32'd1);
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;

    // Pin the reference model against hand-computed words.
    for (int i = 0; i < 11; i++) check($sformatf("model_%08h", vec_in[i]), model(vec_in[i]), vec_out[i]);

    // 1. latency of a single sample
    send(32'd1);
    check("t1_valid_c1", {31'b0, valid_out}, 32'd0);
    @(posedge clk_in);
    #1;
    check("t1_valid_c2", {31'b0, valid_out}, 32'd0);
    @(posedge clk_in);
    #1;
    check("t1_valid_c3", {31'b0, valid_out}, 32'd1);
    check("t1_data", floating_out, 32'h3F800000);
    drain();

    // 2/3. sign, edge and rounding vectors, streamed back to back
    for (int i = 0; i < 10; i++) send(vec_in[i]);
    drain();

    // 4. backpressure
    fork
      begin
        send(32'd1);
        send(32'd2);
        send(32'd3);
        send(32'd4);
      end
      begin
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk_in);
          #1;
          if (valid_out) begin
            seen = 1'b1;
            break;
          end
        end
        check("t4_first_valid", {31'b0, seen}, 32'd1);
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_in);
          check("t4_stall_ready_out", {31'b0, ready_out}, 32'd0);
          check("t4_stall_data", floating_out, 32'h3F800000);
        end
        @(posedge clk_in);
        #1;
        ready_in = 1'b1;
      end
    join
    drain();

    // 5. bubbles 1,0,1
    valid_in   = 1'b1;
    integer_in = 32'd7;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    valid_in   = 1'b1;
    integer_in = 32'd9;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    check("t5_valid_a", {31'b0, valid_out}, 32'd1);
    check("t5_data_a", floating_out, 32'h40E00000);
    @(posedge clk_in);
    #1;
    check("t5_valid_bubble", {31'b0, valid_out}, 32'd0);
    @(posedge clk_in);
    #1;
    check("t5_valid_b", {31'b0, valid_out}, 32'd1);
    check("t5_data_b", floating_out, 32'h41100000);
    drain();

    // 6. reset with two samples in flight (one of them already at the output)
    ready_in = 1'b0;
    send(32'd11);
    send(32'd12);
    @(posedge clk_in);
    #1;
    check("t6_pre_reset_valid", {31'b0, valid_out}, 32'd1);
    reset_in = 1'b1;
    #1;
    check("t6_reset_valid_now", {31'b0, valid_out}, 32'd0);
    check("t6_reset_data_now", floating_out, 32'h0);
    check("t6_reset_ready", {31'b0, ready_out}, 32'd1);
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      check("t6_no_ghost", {31'b0, valid_out}, 32'd0);
    end
    @(posedge clk_in);
    #1;
    send(32'd5);
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1;
    check("t6_new_valid", {31'b0, valid_out}, 32'd1);
    check("t6_new_data", floating_out, 32'h40A00000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
